// File: rtl/dbb_txn_monitor.sv
// dbb_txn_monitor: passive DBB protocol monitor.
// Watches all five DBB channels and never drives the bus. It does four things:
//   - counts outstanding read and write bursts;
//   - checks each W burst length against the length of its AW request;
//   - runs a per-channel watchdog for handshake stalls and for valid drops;
//   - keeps sticky error flags, a one-cycle error pulse and the code of the
//     first error.
// Transaction IDs are carried for port compatibility only. Bursts are not
// tracked per ID.

module dbb_txn_monitor #(
  parameter  int DBB_ALEN_WIDTH      = 4,
  parameter  int DBB_AID_WIDTH       = 8,
  parameter  int DBB_MAX_OUTSTANDING = 32,
  parameter  int DBB_MAXWAITS        = 16,
  localparam int CNT_W               = $clog2(DBB_MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr_err,
  // write address channel
  input  logic                      awvalid,
  input  logic                      awready,
  input  logic [DBB_ALEN_WIDTH-1:0] awlen,
  input  logic [DBB_AID_WIDTH-1:0]  awid,
  // write data channel
  input  logic                      wvalid,
  input  logic                      wready,
  input  logic                      wlast,
  // write response channel
  input  logic                      bvalid,
  input  logic                      bready,
  input  logic [DBB_AID_WIDTH-1:0]  bid,
  // read address channel
  input  logic                      arvalid,
  input  logic                      arready,
  input  logic [DBB_ALEN_WIDTH-1:0] arlen,
  input  logic [DBB_AID_WIDTH-1:0]  arid,
  // read data channel
  input  logic                      rvalid,
  input  logic                      rready,
  input  logic                      rlast,
  input  logic [DBB_AID_WIDTH-1:0]  rid,
  // status
  output logic [CNT_W-1:0]          rd_outstanding,
  output logic [CNT_W-1:0]          wr_outstanding,
  output logic [CNT_W-1:0]          b_pending,
  output logic [7:0]                err_sticky,
  output logic                      err_pulse,
  output logic [2:0]                err_first,
  output logic                      idle
);

  localparam int PTR_W = (DBB_MAX_OUTSTANDING > 1) ? $clog2(DBB_MAX_OUTSTANDING) : 1;
  localparam int WB_W  = DBB_ALEN_WIDTH + 1;
  localparam int WD_W  = $clog2(DBB_MAXWAITS + 2);
  localparam int NCH   = 5;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(DBB_MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DBB_MAX_OUTSTANDING - 1);
  localparam logic [WD_W-1:0]  WD_ARM   = WD_W'(DBB_MAXWAITS);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(DBB_MAXWAITS + 1);

  // Bit index of each error code inside err_sticky.
  typedef enum logic [2:0] {
    E_WLAST_EARLY   = 3'd0,
    E_WLAST_MISSING = 3'd1,
    E_WLAST_NO_AW   = 3'd2,
    E_B_UNEXPECTED  = 3'd3,
    E_R_UNEXPECTED  = 3'd4,
    E_OVF           = 3'd5,
    E_STALL         = 3'd6,
    E_VALID_DROP    = 3'd7
  } err_code_e;

  // IDs and the read length are not needed for burst accounting. They are
  // folded into one signal so that they are visibly consumed.
  logic unused_inputs;
  assign unused_inputs = ^{awid, bid, arid, rid, arlen};

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic aw_hs, w_hs, b_hs, ar_hs, rlast_hs;
  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid  & wready;
  assign b_hs     = bvalid  & bready;
  assign ar_hs    = arvalid & arready;
  assign rlast_hs = rvalid  & rready & rlast;

  // Watchdog arrays use channel order AW, W, B, AR, R (index 0..4).
  logic [NCH-1:0] ch_valid, ch_ready;
  assign ch_valid = {rvalid, arvalid, bvalid, wvalid, awvalid};
  assign ch_ready = {rready, arready, bready, wready, awready};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DBB_ALEN_WIDTH-1:0] len_mem_q [DBB_MAX_OUTSTANDING];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          fifo_cnt_q, fifo_cnt_d;
  logic [WB_W-1:0]           wbeat_q, wbeat_d;
  logic [CNT_W-1:0]          wr_out_q, wr_out_d;
  logic [CNT_W-1:0]          rd_out_q, rd_out_d;
  logic [CNT_W-1:0]          b_pend_q, b_pend_d;
  logic [WD_W-1:0]           wd_q [NCH];
  logic [WD_W-1:0]           wd_d [NCH];
  logic [NCH-1:0]            waiting_q, waiting_d;
  logic [7:0]                err_sticky_q, err_sticky_d;
  logic                      err_pulse_q, err_pulse_d;
  logic [2:0]                err_first_q, err_first_d;
  logic                      idle_q, idle_d;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Saturating up/down counter step. A simultaneous increment and decrement
  // leaves the count unchanged.
  function automatic logic [CNT_W-1:0] count_upd(input logic [CNT_W-1:0] cur,
                                                 input logic             inc,
                                                 input logic             dec);
    logic [CNT_W-1:0] res;
    res = cur;
    if (inc && !dec) begin
      if (cur != MAX_CNT) res = cur + 1'b1;
    end else if (dec && !inc) begin
      if (cur != '0) res = cur - 1'b1;
    end
    return res;
  endfunction

  // Lowest set bit index; used to choose err_first when codes tie.
  function automatic logic [2:0] lowest_code(input logic [7:0] bits);
    logic [2:0] code;
    code = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bits[i]) code = 3'(i);
    end
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // Write path: AW-length FIFO, W beat counter and burst-length checks
  // ---------------------------------------------------------------------------
  logic                      fifo_empty, fifo_full, len_avail;
  logic                      fifo_push, fifo_pop, bp_inc;
  logic                      w_early, w_missing, w_no_aw;
  logic [DBB_ALEN_WIDTH-1:0] head_len;

  // Resolve the length that governs the current W beat, then advance the FIFO
  // and the beat counter.
  // NOTE: every combinational output gets a default at the top of the block,
  // so no path can leave a value unassigned and infer a latch. Combinational
  // blocks use blocking '=' because later lines read the values computed
  // earlier. Flops use '<=' so that all of them update together at the edge.
  always_comb begin
    fifo_empty = (fifo_cnt_q == '0);
    fifo_full  = (fifo_cnt_q == MAX_CNT);
    // When the FIFO is empty, an AW in the same cycle supplies the length
    // directly.
    len_avail  = !fifo_empty || aw_hs;
    head_len   = fifo_empty ? awlen : len_mem_q[rd_ptr_q];

    w_early    = w_hs &&  wlast && len_avail && (wbeat_q <  WB_W'(head_len));
    w_missing  = w_hs && !wlast && len_avail && (wbeat_q == WB_W'(head_len));
    w_no_aw    = w_hs &&  wlast && !len_avail;
    bp_inc     = w_hs &&  wlast && len_avail;

    fifo_push  = aw_hs && !fifo_full;
    fifo_pop   = bp_inc || w_missing;

    wr_ptr_d   = fifo_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = fifo_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;

    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push && !fifo_pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!fifo_push && fifo_pop) fifo_cnt_d = fifo_cnt_q - 1'b1;

    wbeat_d = wbeat_q;
    if (w_hs) begin
      if (wlast || w_missing)  wbeat_d = '0;
      else if (wbeat_q != '1)  wbeat_d = wbeat_q + 1'b1;
    end
  end

  // Outstanding-burst and B-credit counters.
  always_comb begin
    wr_out_d = count_upd(wr_out_q, aw_hs,  b_hs);
    rd_out_d = count_upd(rd_out_q, ar_hs,  rlast_hs);
    b_pend_d = count_upd(b_pend_q, bp_inc, b_hs);
  end

  // ---------------------------------------------------------------------------
  // Per-channel stall watchdogs and valid-drop detection
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] stall_hit, valid_drop;

  // A counter runs while valid is high and ready is low. It stops at the limit,
  // so each stall episode reports only once.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wd_d[c]      = '0;
      stall_hit[c] = 1'b0;
      if (ch_valid[c] && !ch_ready[c]) begin
        wd_d[c]      = (wd_q[c] == WD_LIMIT) ? wd_q[c] : wd_q[c] + 1'b1;
        stall_hit[c] = (wd_q[c] == WD_ARM);
      end
    end
    waiting_d  = ch_valid & ~ch_ready;
    valid_drop = waiting_q & ~ch_valid;
  end

  // ---------------------------------------------------------------------------
  // Error collection
  // ---------------------------------------------------------------------------
  logic [7:0] err_new, err_base;

  // Collect this cycle's error codes. An error raised in the same cycle as
  // clr_err survives the clear.
  always_comb begin
    err_new                  = '0;
    err_new[E_WLAST_EARLY]   = w_early;
    err_new[E_WLAST_MISSING] = w_missing;
    err_new[E_WLAST_NO_AW]   = w_no_aw;
    err_new[E_B_UNEXPECTED]  = b_hs && (b_pend_q == '0);
    err_new[E_R_UNEXPECTED]  = rlast_hs && (rd_out_q == '0);
    err_new[E_OVF]           = (aw_hs  && (fifo_full || (wr_out_q == MAX_CNT))) ||
                               (ar_hs  && (rd_out_q == MAX_CNT)) ||
                               (bp_inc && (b_pend_q == MAX_CNT));
    err_new[E_STALL]         = |stall_hit;
    err_new[E_VALID_DROP]    = |valid_drop;
    if (!en) err_new = '0;

    err_base     = clr_err ? 8'h00 : err_sticky_q;
    err_sticky_d = err_base | err_new;
    err_pulse_d  = |(err_new & ~err_base);
    err_first_d  = clr_err ? 3'd0 : err_first_q;
    if ((err_base == 8'h00) && (err_new != 8'h00)) err_first_d = lowest_code(err_new);
  end

  // Idle means no burst activity remains and no channel presents valid.
  always_comb begin
    idle_d = (wr_out_d == '0) && (rd_out_d == '0) && (b_pend_d == '0) &&
             (fifo_cnt_d == '0) && (wbeat_d == '0) && !(|ch_valid);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Control and status state. Reset discards any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      wbeat_q      <= '0;
      wr_out_q     <= '0;
      rd_out_q     <= '0;
      b_pend_q     <= '0;
      waiting_q    <= '0;
      err_sticky_q <= '0;
      err_pulse_q  <= 1'b0;
      err_first_q  <= '0;
      idle_q       <= 1'b1;
      for (int c = 0; c < NCH; c++) wd_q[c] <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wbeat_q      <= wbeat_d;
      wr_out_q     <= wr_out_d;
      rd_out_q     <= rd_out_d;
      b_pend_q     <= b_pend_d;
      waiting_q    <= waiting_d;
      err_sticky_q <= err_sticky_d;
      err_pulse_q  <= err_pulse_d;
      err_first_q  <= err_first_d;
      idle_q       <= idle_d;
      for (int c = 0; c < NCH; c++) wd_q[c] <= wd_d[c];
    end
  end

  // AW-length storage.
  // NOTE: the length array has no reset. Entries are read only between the
  // pointers, and the pointers and the count are reset. Leaving the storage
  // unreset lets it map onto plain RAM or flops that have no reset network.
  always_ff @(posedge clk) begin
    if (fifo_push) len_mem_q[wr_ptr_q] <= awlen;
  end

  assign rd_outstanding = rd_out_q;
  assign wr_outstanding = wr_out_q;
  assign b_pending      = b_pend_q;
  assign err_sticky     = err_sticky_q;
  assign err_pulse      = err_pulse_q;
  assign err_first      = err_first_q;
  assign idle           = idle_q;

endmodule
